demux1to4_8bit_buf: RTL and testbench

//  Registered 1-to-4 byte distributor; inverse of the 4:1 result-select mux in the datapath.

---
 rtl/demux_pkg.sv | 20 ++
 rtl/demux_lane_buf.sv | 102 ++++++++++
 rtl/demux1to4_8bit_buf.sv | 59 +++++
 tb/tb_demux1to4_8bit_buf.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and lane state encoding for the 1-to-4 byte distributor.
package demux_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } lane_state_e;

    // Saturating increment for the per-lane delivery counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/demux_lane_buf.sv
// One output lane: 2-entry FIFO with head/tail registers and optional delivery counter.
// Counter built only when DEMUX_STATS_EN is defined.
module demux_lane_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    output logic              full,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [STAT_W-1:0] stat_count
);

    lane_state_e      state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             pop;

    assign pop       = (state_q != EMPTY) && out_ready;
    assign full      = (state_q == TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;

    // Head register is kept at zero while the lane is empty.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = push_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    state_d = TWO;
                    tail_d  = push_data;
                end else if (pop) begin
                    state_d = EMPTY;
                    head_d  = '0;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                    tail_d  = '0;
                end
            end
            default: begin
                state_d = EMPTY;
                head_d  = '0;
                tail_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (pop) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign stat_count = count_q;
`else
    assign stat_count = '0;
`endif

endmodule

// File: rtl/demux1to4_8bit_buf.sv
// Registered 1-to-4 byte distributor: in_sel decode feeding four buffered lanes.
// Optional per-lane delivery counters via DEMUX_STATS_EN.
module demux1to4_8bit_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [LANES-1:0]  out_valid,
    input  logic [LANES-1:0]  out_ready,
    output logic [WIDTH-1:0]  out_data0,
    output logic [WIDTH-1:0]  out_data1,
    output logic [WIDTH-1:0]  out_data2,
    output logic [WIDTH-1:0]  out_data3,
    output logic [STAT_W-1:0] stat_count0,
    output logic [STAT_W-1:0] stat_count1,
    output logic [STAT_W-1:0] stat_count2,
    output logic [STAT_W-1:0] stat_count3
);

    logic [LANES-1:0]  lane_full;
    logic [LANES-1:0]  lane_push;
    logic [WIDTH-1:0]  lane_data  [LANES];
    logic [STAT_W-1:0] lane_count [LANES];

    // Ready depends only on registered fullness of the selected lane.
    assign in_ready = ~lane_full[in_sel];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_push[k] = in_valid && in_ready && (in_sel == SEL_W'(k));

        demux_lane_buf #(.WIDTH(WIDTH)) u_lane (
            .clock      (clock),
            .reset      (reset),
            .push       (lane_push[k]),
            .push_data  (in_data),
            .full       (lane_full[k]),
            .out_valid  (out_valid[k]),
            .out_ready  (out_ready[k]),
            .out_data   (lane_data[k]),
            .stat_count (lane_count[k])
        );
    end

    assign out_data0   = lane_data[0];
    assign out_data1   = lane_data[1];
    assign out_data2   = lane_data[2];
    assign out_data3   = lane_data[3];
    assign stat_count0 = lane_count[0];
    assign stat_count1 = lane_count[1];
    assign stat_count2 = lane_count[2];
    assign stat_count3 = lane_count[3];

endmodule

// File: tb/tb_demux1to4_8bit_buf.sv
// Bench for demux1to4_8bit_buf: directed scenarios plus randomized traffic against a queue model.
module tb_demux1to4_8bit_buf;

`ifdef DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic [1:0]  in_sel = 2'd0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'h0;
    logic [7:0]  out_data0, out_data1, out_data2, out_data3;
    logic [15:0] stat_count0, stat_count1, stat_count2, stat_count3;

    logic [7:0]  od [4];
    logic [15:0] sc [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;
    assign sc[0] = stat_count0;
    assign sc[1] = stat_count1;
    assign sc[2] = stat_count2;
    assign sc[3] = stat_count3;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-lane FIFO of at most two words plus delivery totals.
    logic [7:0] mq [4][2];
    int         m_len [4];
    int         m_cnt [4];

    demux1to4_8bit_buf dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data0   (out_data0),
        .out_data1   (out_data1),
        .out_data2   (out_data2),
        .out_data3   (out_data3),
        .stat_count0 (stat_count0),
        .stat_count1 (stat_count1),
        .stat_count2 (stat_count2),
        .stat_count3 (stat_count3)
    );

    always #5 clock = ~clock;

    function automatic int exp_cnt(input int k);
        return STATS ? m_cnt[k] : 0;
    endfunction

    // Advance one clock; the model applies the same handshake rules to the pre-edge state.
    task automatic tick();
        bit acc;
        bit pop [4];
        acc = in_valid && (m_len[in_sel] < 2);
        for (int k = 0; k < 4; k++) pop[k] = out_ready[k] && (m_len[k] > 0);
        @(posedge clock);
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                m_len[k] = 0;
                m_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (pop[k]) begin
                    mq[k][0] = mq[k][1];
                    m_len[k] = m_len[k] - 1;
                    if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
                end
            end
            if (acc) begin
                mq[in_sel][m_len[in_sel]] = in_data;
                m_len[in_sel] = m_len[in_sel] + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (od[k] !== 8'h00) begin
                n_err++; $display("FAIL reset_out_data%0d: got %h expected 00", k, od[k]);
            end
            n_vec++;
            if (sc[k] !== 16'h0000) begin
                n_err++; $display("FAIL reset_stat%0d: got %h expected 0000", k, sc[k]);
            end
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'hF;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL single_in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 4'b0100) begin
            n_err++; $display("FAIL single_out_valid: got %b expected 0100", out_valid);
        end
        n_vec++;
        if (od[2] !== 8'hA5) begin
            n_err++; $display("FAIL single_out_data2: got %h expected a5", od[2]);
        end
        tick();
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++; $display("FAIL single_popped: got %b expected 0000", out_valid);
        end
        n_vec++;
        if (sc[2] !== (STATS ? 16'd1 : 16'd0)) begin
            n_err++; $display("FAIL single_stat2: got %h expected %h", sc[2], STATS ? 16'd1 : 16'd0);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0; in_sel = 2'd1;
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_ready_full_lane: got %b expected 0", in_ready);
        end
        in_sel = 2'd0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_ready_other_lane: got %b expected 1", in_ready);
        end
        in_valid = 1'b1; in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid[0] !== 1'b1 || od[0] !== 8'h33) begin
            n_err++; $display("FAIL bp_lane0: got v=%b d=%h expected v=1 d=33", out_valid[0], od[0]);
        end
        n_vec++;
        if (out_valid[1] !== 1'b1 || od[1] !== 8'h11) begin
            n_err++; $display("FAIL bp_lane1_hold: got v=%b d=%h expected v=1 d=11", out_valid[1], od[1]);
        end
        tick();
    endtask

    task automatic test_push_pop();
        out_ready = 4'b0010; in_valid = 1'b0;
        tick();
        n_vec++;
        if (od[1] !== 8'h22) begin
            n_err++; $display("FAIL pp_promote: got %h expected 22", od[1]);
        end
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h44;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL pp_ready_one: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        n_vec++;
        if (out_valid[1] !== 1'b1 || od[1] !== 8'h44) begin
            n_err++; $display("FAIL pp_head: got v=%b d=%h expected v=1 d=44", out_valid[1], od[1]);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL pp_still_one: got %b expected 1", in_ready);
        end
        out_ready = 4'hF;
        tick();
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++; $display("FAIL pp_drain: got %b expected 0000", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 4'h0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2; j++) begin
                in_valid = 1'b1; in_sel = 2'(k); in_data = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 4'hF) begin
            n_err++; $display("FAIL rm_all_valid: got %b expected 1111", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            in_sel = 2'(k);
            #1;
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL rm_full%0d: got %b expected 0", k, in_ready);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 4'h0) begin
            n_err++; $display("FAIL rm_after_valid: got %b expected 0000", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            in_sel = 2'(k);
            #1;
            n_vec++;
            if (in_ready !== 1'b1 || od[k] !== 8'h00 || sc[k] !== 16'h0000) begin
                n_err++; $display("FAIL rm_lane%0d: got r=%b d=%h c=%h expected r=1 d=00 c=0000",
                                  k, in_ready, od[k], sc[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(63) == 0);
            in_valid  = 1'($urandom);
            in_sel    = 2'($urandom);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            #1;
            n_vec++;
            if (in_ready !== (m_len[in_sel] < 2)) begin
                n_err++; $display("FAIL rnd_in_ready i=%0d: got %b expected %b", i, in_ready, m_len[in_sel] < 2);
            end
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (out_valid[k] !== (m_len[k] > 0)) begin
                    n_err++; $display("FAIL rnd_valid%0d i=%0d: got %b expected %b", k, i, out_valid[k], m_len[k] > 0);
                end
                n_vec++;
                if (od[k] !== ((m_len[k] > 0) ? mq[k][0] : 8'h00)) begin
                    n_err++; $display("FAIL rnd_data%0d i=%0d: got %h expected %h", k, i, od[k],
                                      (m_len[k] > 0) ? mq[k][0] : 8'h00);
                end
                n_vec++;
                if (sc[k] !== 16'(exp_cnt(k))) begin
                    n_err++; $display("FAIL rnd_stat%0d i=%0d: got %h expected %h", k, i, sc[k], 16'(exp_cnt(k)));
                end
            end
            tick();
        end
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_saturate();
        int n;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = STATS ? 65540 : 200;
        in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'b0001;
        for (int i = 0; i < n; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        n_vec++;
        if (sc[0] !== 16'(exp_cnt(0))) begin
            n_err++; $display("FAIL sat_stat0: got %h expected %h", sc[0], 16'(exp_cnt(0)));
        end
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++; $display("FAIL sat_drained: got %b expected 0000", out_valid);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_len[k] = 0;
            m_cnt[k] = 0;
            mq[k][0] = 8'h00;
            mq[k][1] = 8'h00;
        end
        test_reset();
        test_single();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
